// File: rtl/io_timer_intc_pkg.sv
// io_timer_intc_pkg: register map, bit positions and interrupt FSM states
// shared by the timer/interrupt controller and its prescaler.
package io_timer_intc_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    localparam int ST_PEND = 0;
    localparam int ST_OVR  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACKD = 2'd2
    } irq_state_e;

endpackage

// File: rtl/io_timer_prescaler.sv
// io_timer_prescaler: divides clk by PRESCALE while enabled and emits a one-cycle tick on wrap.
// clr_i restarts the division from zero and suppresses that cycle's tick.
module io_timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap;

    assign wrap   = cnt_q == LAST;
    assign tick_o = en_i & ~clr_i & wrap;

    always_comb cnt_d = (!en_i || clr_i || wrap) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/io_timer_intc.sv
// io_timer_intc: memory-mapped countdown timer with a request/acknowledge interrupt
// handshake toward the CPU on the shared I/O bus.
module io_timer_intc
    import io_timer_intc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_cs,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [31:0] io_address,
    input  logic [31:0] io_d_in,
    output logic [31:0] io_out,
    output logic        intr,
    input  logic        inta
);

    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic [1:0]  status_q, status_d;
    irq_state_e  state_q, state_d;

    logic        sel, wr, wr_ctrl, wr_load, wr_status;
    logic        clr_pend, clr_ovr, tick, expire;
    logic [31:0] rdata;
    logic        unused_addr;

    assign unused_addr = ^io_address[1:0];

    assign sel       = io_cs & (io_address[31:4] == BASE_ADDR[31:4]);
    assign wr        = sel & io_wr;
    assign wr_ctrl   = wr & (io_address[3:2] == REG_CTRL);
    assign wr_load   = wr & (io_address[3:2] == REG_LOAD);
    assign wr_status = wr & (io_address[3:2] == REG_STATUS);
    assign clr_pend  = wr_status & io_d_in[ST_PEND];
    assign clr_ovr   = wr_status & io_d_in[ST_OVR];

    io_timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en_i   (ctrl_q[CTRL_EN]),
        .clr_i  (wr_load),
        .tick_o (tick)
    );

    assign expire = tick & (count_q == 32'd0);

    // A same-cycle expire outranks the W1C of PEND and does not count as an overrun.
    always_comb begin
        load_d            = wr_load ? io_d_in : load_q;
        count_d           = wr_load ? io_d_in :
                            !tick   ? count_q :
                            expire  ? (ctrl_q[CTRL_AUTO] ? load_q : count_q) :
                                      count_q - 32'd1;
        ctrl_d            = wr_ctrl ? io_d_in[2:0] :
                            (expire && !ctrl_q[CTRL_AUTO]) ? {ctrl_q[2:1], 1'b0} : ctrl_q;
        status_d[ST_PEND] = expire | (status_q[ST_PEND] & ~clr_pend);
        status_d[ST_OVR]  = (expire & status_q[ST_PEND] & ~clr_pend) | (status_q[ST_OVR] & ~clr_ovr);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (status_q[ST_PEND] && ctrl_q[CTRL_IE]) ? REQ : IDLE;
            REQ:     state_d = inta ? ACKD : !ctrl_q[CTRL_IE] ? IDLE : REQ;
            ACKD:    state_d = status_q[ST_PEND] ? ACKD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= '0;
            load_q   <= '0;
            count_q  <= '0;
            status_q <= '0;
            state_q  <= IDLE;
        end else begin
            ctrl_q   <= ctrl_d;
            load_q   <= load_d;
            count_q  <= count_d;
            status_q <= status_d;
            state_q  <= state_d;
        end
    end

    assign intr = state_q == REQ;

    assign rdata  = (io_address[3:2] == REG_CTRL)  ? {29'b0, ctrl_q} :
                    (io_address[3:2] == REG_LOAD)  ? load_q :
                    (io_address[3:2] == REG_COUNT) ? count_q : {30'b0, status_q};
    assign io_out = (sel & io_rd) ? rdata : 32'h0;

endmodule

// File: tb/tb_io_timer_intc.sv
// tb_io_timer_intc: scoreboard bench for the timer/interrupt controller, one instance
// with PRESCALE=1 and one with PRESCALE=4 sharing the bus strobes.
module tb_io_timer_intc;
    import io_timer_intc_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0100;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs1 = 1'b0, cs4 = 1'b0, io_rd = 1'b0, io_wr = 1'b0;
    logic        inta1 = 1'b0, inta4 = 1'b0;
    logic [31:0] io_address = '0, io_d_in = '0;
    logic [31:0] out1, out4;
    logic        intr1, intr4;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    io_timer_intc #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(rst_n), .io_cs(cs1), .io_rd(io_rd), .io_wr(io_wr),
        .io_address(io_address), .io_d_in(io_d_in), .io_out(out1), .intr(intr1), .inta(inta1)
    );

    io_timer_intc #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(rst_n), .io_cs(cs4), .io_rd(io_rd), .io_wr(io_wr),
        .io_address(io_address), .io_d_in(io_d_in), .io_out(out4), .intr(intr4), .inta(inta4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wr(input bit d4, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        io_address = BASE | {28'b0, a, 2'b00};
        io_d_in    = d;
        cs1        = !d4;
        cs4        = d4;
        io_wr      = 1'b1;
        @(posedge clk);
        #1;
        io_wr = 1'b0;
        cs1   = 1'b0;
        cs4   = 1'b0;
    endtask

    task automatic rd(input bit d4, input logic [1:0] a, input string tag,
                      input logic [31:0] exp, input bit sync = 1'b1);
        exp_t e;
        if (sync) @(negedge clk);
        sb.push_back('{tag: tag, exp: exp});
        io_address = BASE | {28'b0, a, 2'b00};
        cs1        = !d4;
        cs4        = d4;
        io_rd      = 1'b1;
        #1;
        e = sb.pop_front();
        check(e.tag, d4 ? out4 : out1, e.exp);
        io_rd = 1'b0;
        cs1   = 1'b0;
        cs4   = 1'b0;
    endtask

    task automatic chk_intr(input bit d4, input string tag, input logic exp);
        exp_t e;
        sb.push_back('{tag: tag, exp: {31'b0, exp}});
        #1;
        e = sb.pop_front();
        check(e.tag, {31'b0, d4 ? intr4 : intr1}, e.exp);
    endtask

    task automatic pulse_inta(input bit d4);
        @(negedge clk);
        if (d4) inta4 = 1'b1;
        else    inta1 = 1'b1;
        @(posedge clk);
        #1;
        inta1 = 1'b0;
        inta4 = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] t4_cnt [6];
        t4_cnt = '{32'd2, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0};

        cyc(2);
        chk_intr(0, "rst_intr", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(0, REG_CTRL, "init_ctrl", 32'h0);
        rd(0, REG_STATUS, "init_status", 32'h0);

        // one-shot countdown from 3 with interrupt enabled
        wr(0, REG_LOAD, 32'd3);
        wr(0, REG_CTRL, 32'h5);
        rd(0, REG_COUNT, "os_cnt3", 32'd3);
        rd(0, REG_COUNT, "os_cnt2", 32'd2);
        rd(0, REG_COUNT, "os_cnt1", 32'd1);
        rd(0, REG_COUNT, "os_cnt0", 32'd0);
        rd(0, REG_STATUS, "os_pend", 32'd1);
        chk_intr(0, "os_intr_lat", 1'b0);
        rd(0, REG_CTRL, "os_en_clr", 32'd4);
        chk_intr(0, "os_intr", 1'b1);

        // acknowledge, then clear PEND from the handler
        pulse_inta(0);
        chk_intr(0, "ack_drop", 1'b0);
        cyc(1);
        chk_intr(0, "ack_low", 1'b0);
        wr(0, REG_STATUS, 32'd1);
        rd(0, REG_STATUS, "ack_w1c", 32'd0);
        chk_intr(0, "ack_low2", 1'b0);
        cyc(1);
        chk_intr(0, "idle_low", 1'b0);

        // auto-reload period of three ticks, overrun on second expire
        wr(0, REG_STATUS, 32'd3);
        wr(0, REG_LOAD, 32'd2);
        wr(0, REG_CTRL, 32'h3);
        for (int i = 0; i < 6; i++) rd(0, REG_COUNT, $sformatf("auto_cnt%0d", i), t4_cnt[i]);
        rd(0, REG_STATUS, "auto_ovr", 32'd3);

        // expire collides with PEND W1C
        wr(0, REG_STATUS, 32'd2);
        wr(0, REG_STATUS, 32'd1);
        rd(0, REG_STATUS, "race_w1c", 32'd1);
        wr(0, REG_CTRL, 32'h0);
        rd(0, REG_COUNT, "stop_cnt", 32'd0);
        wr(0, REG_COUNT, 32'd7);
        rd(0, REG_COUNT, "cnt_ro", 32'd0);

        @(negedge clk);
        sb.push_back('{tag: "bad_base", exp: 32'h0});
        io_address = 32'h0000_0208;
        cs1        = 1'b1;
        io_rd      = 1'b1;
        #1;
        check(sb[0].tag, out1, sb[0].exp);
        void'(sb.pop_front());
        io_rd = 1'b0;
        cs1   = 1'b0;

        // prescaled one-shot, request withdrawn by clearing IE
        wr(1, REG_LOAD, 32'd1);
        wr(1, REG_CTRL, 32'h5);
        for (int i = 0; i < 9; i++) rd(1, REG_STATUS, $sformatf("ps_st%0d", i), (i == 8) ? 32'd1 : 32'd0);
        chk_intr(1, "ps_intr_lat", 1'b0);
        cyc(1);
        chk_intr(1, "ps_intr", 1'b1);
        wr(1, REG_CTRL, 32'h0);
        chk_intr(1, "ps_ie_hold", 1'b1);
        cyc(2);
        chk_intr(1, "ps_ie_drop", 1'b0);

        // asynchronous reset while a request is active
        wr(0, REG_LOAD, 32'd5);
        wr(0, REG_CTRL, 32'h7);
        cyc(2);
        chk_intr(0, "pre_rst_intr", 1'b1);
        rd(0, REG_LOAD, "pre_rst_load", 32'd5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        chk_intr(0, "arst_intr", 1'b0);
        rd(0, REG_CTRL, "arst_ctrl", 32'h0, 1'b0);
        rd(0, REG_LOAD, "arst_load", 32'h0, 1'b0);
        rd(0, REG_COUNT, "arst_count", 32'h0, 1'b0);
        rd(0, REG_STATUS, "arst_status", 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
